// File: rtl/debounce_pkg.sv
// Shared types for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_counter.sv
// Stability counter: clear / load-1 / increment, with terminal-count flag at STABLE_CYCLES-1.
module debounce_counter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (load)  cnt <= CNT_W'(1);
    else if (inc)   cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(STABLE_CYCLES - 1));

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: level follows sw after STABLE_CYCLES equal samples, tick on rising accept.
// Optional DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module sw_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  state_t state;
  logic   s;
  logic   clear, load, inc, tc;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], sw};
  end
  assign s = sync[1];
`else
  assign s = sw;
`endif

  debounce_counter #(.STABLE_CYCLES(STABLE_CYCLES)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .load  (load),
    .inc   (inc),
    .tc    (tc)
  );

  // Counter control mirrors the FSM transitions below.
  always_comb begin
    clear = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
    case (state)
      ZERO:    load = s;
      WAIT1:   if (!s || tc) clear = 1'b1; else inc = 1'b1;
      ONE:     load = !s;
      WAIT0:   if (s || tc) clear = 1'b1; else inc = 1'b1;
      default: clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ZERO;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      db_tick <= 1'b0;
      case (state)
        ZERO:  if (s) state <= WAIT1;
        WAIT1: begin
          if (!s) state <= ZERO;
          else if (tc) begin
            state    <= ONE;
            db_level <= 1'b1;
            db_tick  <= 1'b1;
          end
        end
        ONE:   if (!s) state <= WAIT0;
        WAIT0: begin
          if (s) state <= ONE;
          else if (tc) begin
            state    <= ZERO;
            db_level <= 1'b0;
          end
        end
        default: begin
          state    <= ZERO;
          db_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (STABLE_CYCLES=4, no synchronizer).
module tb_sw_debounce;

  typedef struct packed {
    logic lvl;
    logic tick;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw = 1'b0;
  logic db_level, db_tick;

  exp_t exp_q[$];
  int   tag_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  sw_debounce #(.STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  always #10 clk = ~clk;

  // Drive one sample away from the edge and record what the outputs must be after it.
  task automatic step(input logic r, input logic s, input logic el, input logic et);
    exp_t e;
    @(negedge clk);
    reset = r;
    sw    = s;
    e.lvl  = el;
    e.tick = et;
    exp_q.push_back(e);
    tag_q.push_back(step_no);
    step_no++;
  endtask

  initial begin : monitor
    exp_t e;
    int   tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        n_checks++;
        if (db_level !== e.lvl) begin
          n_fail++;
          $display("FAIL db_level step %0d: got %b expected %b", tag, db_level, e.lvl);
        end
        n_checks++;
        if (db_tick !== e.tick) begin
          n_fail++;
          $display("FAIL db_tick step %0d: got %b expected %b", tag, db_tick, e.tick);
        end
      end
    end
  end

  initial begin : stim
    // 1: reset held with sw toggling
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    // 2: sw=1 held, accept on 4th edge, tick one cycle only
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 0);
    // 4: falling accept, no tick
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // 3: glitchy highs from ZERO rejected
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    // back to ONE
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    // 5: 0,0,0,1 from ONE stays ONE
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    // fall count restarts from scratch after the abort
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    // 6: reset in WAIT1 at cnt=2 discards progress
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 0);
    // reset from ONE clears level; rise needs 4 fresh samples
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
